// File: rtl/bcd_seg_display_if.sv
// Handshake and display bus between a result producer and bcd_seg_display.
// The master drives start/value; the slave (the converter) returns status and display data.
interface bcd_seg_display_if #(
    parameter int BIN_W      = 11,
    parameter int NUM_DIGITS = 4
);
    logic                    start;
    logic [BIN_W-1:0]        value;
    logic                    busy;
    logic                    done;
    logic                    overflow;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [7*NUM_DIGITS-1:0] segments;

    modport master (output start, value, input busy, done, overflow, bcd_out, segments);
    modport slave  (input start, value, output busy, done, overflow, bcd_out, segments);
endinterface

// File: rtl/bcd_seg_display.sv
// Serial double-dabble binary-to-BCD converter driving active-low seven-segment digits.
// Define BCD_SEG_SIGNED_EN to treat value as two's complement with a sign digit on top.
module bcd_seg_display #(
    parameter int BIN_W      = 11,
    parameter int NUM_DIGITS = 4,
    parameter int BLANK_LZ   = 1
) (
    input  logic             clk,
    input  logic             reset,
    bcd_seg_display_if.slave bus
);
    localparam int INT_D = (NUM_DIGITS > (BIN_W + 2) / 3) ? NUM_DIGITS : (BIN_W + 2) / 3;
    localparam int CW    = $clog2(BIN_W + 1);
`ifdef BCD_SEG_SIGNED_EN
    localparam int NUM_N = NUM_DIGITS - 1;
`else
    localparam int NUM_N = NUM_DIGITS;
`endif

    typedef enum logic [1:0] {IDLE, ADD3, SHIFT, LATCH} state_e;

    state_e                  state_q, state_d;
    logic [BIN_W-1:0]        bin_q, bin_d;
    logic [4*INT_D-1:0]      bcd_q, bcd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    done_q, ovf_q;
    logic [4*NUM_DIGITS-1:0] bcd_out_q;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic                    ovf_c;
    logic [4*NUM_DIGITS-1:0] bcd_c;
    logic [7*NUM_DIGITS-1:0] seg_c;
    logic                    shown;
    logic [BIN_W-1:0]        mag;
`ifdef BCD_SEG_SIGNED_EN
    logic                    neg_q, neg_d;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    function automatic logic [7*NUM_DIGITS-1:0] reset_seg();
        reset_seg      = {NUM_DIGITS{(BLANK_LZ != 0) ? 7'h7F : 7'h40}};
`ifdef BCD_SEG_SIGNED_EN
        reset_seg[7*(NUM_DIGITS-1) +: 7] = 7'h7F;
`endif
        reset_seg[6:0] = 7'h40;
    endfunction

`ifdef BCD_SEG_SIGNED_EN
    // Two's-complement negate also maps -2^(BIN_W-1) onto its unsigned magnitude.
    assign mag = bus.value[BIN_W-1] ? (~bus.value + BIN_W'(1)) : bus.value;
`else
    assign mag = bus.value;
`endif

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
`ifdef BCD_SEG_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                bin_d   = mag;
                bcd_d   = '0;
                cnt_d   = '0;
`ifdef BCD_SEG_SIGNED_EN
                neg_d   = bus.value[BIN_W-1];
`endif
                state_d = ADD3;
            end
            ADD3: begin
                for (int i = 0; i < INT_D; i++)
                    if (bcd_q[4*i +: 4] > 4'd4) bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_q, bin_q} << 1;
                cnt_d          = cnt_q + CW'(1);
                state_d        = (cnt_q == CW'(BIN_W - 1)) ? LATCH : ADD3;
            end
            default: state_d = IDLE;
        endcase
    end

    // Display image derived from the finished BCD register; only captured in LATCH.
    always_comb begin
        ovf_c = 1'b0;
        for (int i = 0; i < INT_D; i++)
            if (i >= NUM_N && bcd_q[4*i +: 4] != 4'd0) ovf_c = 1'b1;
        seg_c = '1;
        shown = (BLANK_LZ == 0);
        for (int i = NUM_N - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0 || i == 0) shown = 1'b1;
            seg_c[7*i +: 7] = shown ? seg7(bcd_q[4*i +: 4]) : 7'h7F;
        end
        bcd_c = bcd_q[4*NUM_DIGITS-1:0];
`ifdef BCD_SEG_SIGNED_EN
        seg_c[7*(NUM_DIGITS-1) +: 7] = neg_q ? 7'h3F : 7'h7F;
        bcd_c[4*(NUM_DIGITS-1) +: 4] = neg_q ? 4'hF : 4'h0;
`endif
        if (ovf_c) seg_c = {NUM_DIGITS{7'h3F}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_out_q <= '0;
            seg_q     <= reset_seg();
`ifdef BCD_SEG_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == LATCH);
`ifdef BCD_SEG_SIGNED_EN
            neg_q   <= neg_d;
`endif
            if (state_q == LATCH) begin
                ovf_q     <= ovf_c;
                bcd_out_q <= bcd_c;
                seg_q     <= seg_c;
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.bcd_out  = bcd_out_q;
    assign bus.segments = seg_q;
endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed bench for bcd_seg_display: three instances cover 4 digits blanked,
// 3 digits blanked and 4 digits unblanked.
module tb_bcd_seg_display;
    logic clk = 1'b0;
    logic reset;
    int   nvec  = 0;
    int   nfail = 0;
    int   lat, n, dc;

    always #5 clk = ~clk;

    bcd_seg_display_if #(.BIN_W(11), .NUM_DIGITS(4)) if0 ();
    bcd_seg_display_if #(.BIN_W(11), .NUM_DIGITS(3)) if1 ();
    bcd_seg_display_if #(.BIN_W(11), .NUM_DIGITS(4)) if2 ();

    bcd_seg_display #(.BIN_W(11), .NUM_DIGITS(4), .BLANK_LZ(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
    bcd_seg_display #(.BIN_W(11), .NUM_DIGITS(3), .BLANK_LZ(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    bcd_seg_display #(.BIN_W(11), .NUM_DIGITS(4), .BLANK_LZ(0)) u2 (.clk(clk), .reset(reset), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        assert (act === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic dn(input int id);
        case (id)
            0:       dn = if0.done;
            1:       dn = if1.done;
            default: dn = if2.done;
        endcase
    endfunction

    // Returns the number of edges from the accepting edge until done is seen (100 = timeout).
    task automatic run(input int id, input logic [10:0] v, output int l);
        @(negedge clk);
        case (id)
            0:       begin if0.start = 1'b1; if0.value = v; end
            1:       begin if1.start = 1'b1; if1.value = v; end
            default: begin if2.start = 1'b1; if2.value = v; end
        endcase
        @(posedge clk); #1;
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        l = 0;
        while (!dn(id) && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        if0.value = '0;   if1.value = '0;   if2.value = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", if0.busy, 1'b0);
        chk("rst_done", if0.done, 1'b0);
        chk("rst_ovf",  if0.overflow, 1'b0);
        chk("rst_bcd",  if0.bcd_out, 16'h0);
        chk("rst_seg0", if0.segments, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        chk("rst_seg1", if1.segments, {7'h7F, 7'h7F, 7'h40});
`ifdef BCD_SEG_SIGNED_EN
        chk("rst_seg2", if2.segments, {7'h7F, 7'h40, 7'h40, 7'h40});
`else
        chk("rst_seg2", if2.segments, {7'h40, 7'h40, 7'h40, 7'h40});
`endif
        @(negedge clk) reset = 1'b0;

`ifdef BCD_SEG_SIGNED_EN
        run(0, 11'h7FB, lat);
        chk("neg5_lat", lat, 23);
        chk("neg5_seg", if0.segments, {7'h3F, 7'h7F, 7'h7F, 7'h12});
        chk("neg5_bcd", if0.bcd_out, 16'hF005);
        chk("neg5_ovf", if0.overflow, 1'b0);
        run(0, 11'h400, lat);
        chk("neg1024_ovf", if0.overflow, 1'b1);
        chk("neg1024_seg", if0.segments, {4{7'h3F}});
        run(0, 11'd42, lat);
        chk("pos42_ovf", if0.overflow, 1'b0);
        chk("pos42_seg", if0.segments, {7'h7F, 7'h7F, 7'h19, 7'h24});
        chk("pos42_bcd", if0.bcd_out, 16'h0042);
`else
        run(0, 11'd2047, lat);
        chk("max_lat", lat, 23);
        chk("max_bcd", if0.bcd_out, 16'h2047);
        chk("max_seg", if0.segments, {7'h24, 7'h40, 7'h19, 7'h78});
        chk("max_ovf", if0.overflow, 1'b0);
        @(posedge clk); #1;
        chk("done_width", if0.done, 1'b0);

        run(0, 11'd0, lat);
        chk("zero_blank", if0.segments, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        run(0, 11'd7, lat);
        chk("seven_blank", if0.segments, {7'h7F, 7'h7F, 7'h7F, 7'h78});
        run(2, 11'd7, lat);
        chk("seven_noblank", if2.segments, {7'h40, 7'h40, 7'h40, 7'h78});
        run(2, 11'd0, lat);
        chk("zero_noblank", if2.segments, {7'h40, 7'h40, 7'h40, 7'h40});

        run(1, 11'd1234, lat);
        chk("ovf_flag", if1.overflow, 1'b1);
        chk("ovf_seg",  if1.segments, {7'h3F, 7'h3F, 7'h3F});
        chk("ovf_bcd",  if1.bcd_out, 12'h234);
        run(1, 11'd999, lat);
        chk("n999_ovf", if1.overflow, 1'b0);
        chk("n999_seg", if1.segments, {7'h10, 7'h10, 7'h10});
        chk("n999_bcd", if1.bcd_out, 12'h999);

        // Handshake: stray starts while busy, then a start in the done cycle.
        @(negedge clk);
        if0.start = 1'b1; if0.value = 11'd2047;
        @(posedge clk); #1;
        if0.start = 1'b0;
        n = 0;
        while (!if0.done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if0.start = (n == 5 || n == 12);
            if0.value = (n == 5 || n == 12) ? 11'd5 : 11'd2047;
        end
        chk("hs_lat1", n, 23);
        chk("hs_bcd1", if0.bcd_out, 16'h2047);
        if0.start = 1'b1; if0.value = 11'd42;
        @(posedge clk); #1;
        if0.start = 1'b0;
        chk("hs_busy", if0.busy, 1'b1);
        n = 1;
        while (!if0.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hs_b2b", n, 24);
        chk("hs_bcd2", if0.bcd_out, 16'h0042);

        // Reset during a conversion.
        @(negedge clk);
        if0.start = 1'b1; if0.value = 11'd2047;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", if0.busy, 1'b0);
        chk("abort_done", if0.done, 1'b0);
        chk("abort_bcd",  if0.bcd_out, 16'h0);
        chk("abort_seg",  if0.segments, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        @(negedge clk) reset = 1'b0;
        dc = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (if0.done) dc++;
        end
        chk("abort_nodone", dc, 0);
        run(0, 11'd42, lat);
        chk("post_lat", lat, 23);
        chk("post_bcd", if0.bcd_out, 16'h0042);
        chk("post_seg", if0.segments, {7'h7F, 7'h7F, 7'h19, 7'h24});
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
